// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, all active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Nibble to active-low seven-segment pattern.
// Non-decimal nibbles render as a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Three-digit multiplexed seven-segment driver with
// leading-zero blanking and an inter-digit guard gap.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] bcd,
  input  logic        bcd_valid,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int CMAX =
    (REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD;
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] SHOW_LAST =
    CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(GUARD - 1);

  scan_state_t   state, state_n;
  logic [1:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [11:0]   val;

  logic [3:0]    nib;
  logic [6:0]    pat;
  logic          blank;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + CW'(1);
    unique case (state)
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
          case (idx)
            2'd0:    idx_n = 2'd1;
            2'd1:    idx_n = 2'd2;
            default: idx_n = 2'd0;
          endcase
        end
      end
      default: begin
        state_n = SHOW;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are derived from next-state so they line up
  // with the FSM; val is the pre-capture value.
  always_comb begin
    nib = val[3:0];
    case (idx_n)
      2'd1:    nib = val[7:4];
      2'd2:    nib = val[11:8];
      default: nib = val[3:0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .nib (nib),
    .seg (pat)
  );

  always_comb begin
    blank = 1'b0;
    if (blank_lz) begin
      if (idx_n == 2'd2)
        blank = (val[11:8] == 4'd0);
      else if (idx_n == 2'd1)
        blank = (val[11:4] == 8'd0);
    end
  end

  always_comb begin
    an_n  = AN_OFF;
    seg_n = SEG_OFF;
    if (state_n == SHOW && !blank) begin
      an_n  = ~(4'b0001 << idx_n);
      seg_n = pat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val   <= '0;
      state <= SHOW;
      idx   <= 2'd0;
      cnt   <= '0;
      an    <= AN_OFF;
      seg   <= SEG_OFF;
    end else begin
      if (bcd_valid)
        val <= bcd;
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      an    <= an_n;
      seg   <= seg_n;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: position-in-period reference model
// checked every cycle, plus directed literal checks.
module tb_seg7_scan;

  localparam int RD  = 4;
  localparam int GD  = 1;
  localparam int SL  = RD + GD;
  localparam int PER = 3 * SL;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk       (clk),
    .reset     (reset),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .an        (an),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [16];
  initial begin
    pat[0] = 7'b1000000; pat[1] = 7'b1111001;
    pat[2] = 7'b0100100; pat[3] = 7'b0110000;
    pat[4] = 7'b0011001; pat[5] = 7'b0010010;
    pat[6] = 7'b0000010; pat[7] = 7'b1111000;
    pat[8] = 7'b0000000; pat[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) pat[i] = 7'b0111111;
  end

  // Model: p is the cycle position inside a scan period.
  int         p = 0;
  int         mval = 0;
  bit         mready = 0;
  logic [3:0] ean;
  logic [6:0] eseg;

  always @(posedge clk) begin
    int slot, dig, h, t;
    bit blk;
    if (reset) begin
      p = 0; mval = 0;
      ean = 4'hF; eseg = 7'h7F;
      mready = 1;
    end else if (mready) begin
      p = (p + 1) % PER;
      slot = p / SL;
      h = (mval / 256) % 16;
      t = (mval / 16) % 16;
      dig = (mval >> (4 * slot)) % 16;
      blk = blank_lz &&
            ((slot == 2 && h == 0) ||
             (slot == 1 && h == 0 && t == 0));
      if ((p % SL) >= RD || blk) begin
        ean = 4'hF; eseg = 7'h7F;
      end else begin
        ean = 4'hF ^ (4'd1 << slot);
        eseg = pat[dig];
      end
      if (bcd_valid) mval = int'(bcd);
    end
  end

  always @(negedge clk) begin
    if (mready) begin
      n_cmp++;
      if (an !== ean || seg !== eseg || dp !== 1'b1) begin
        n_bad++;
        $display("FAIL cycle p=%0d an/seg/dp got %b/%b/%b want %b/%b/1",
                 p, an, seg, dp, ean, eseg);
      end
    end
  end

  task automatic check(input string nm,
                       input logic [10:0] act,
                       input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic capture(input logic [11:0] v);
    bcd = v; bcd_valid = 1'b1;
    step(1);
    bcd_valid = 1'b0;
  endtask

  task automatic wait_p(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      if (p == target) begin ok = 1; break; end
      step(1);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_p timeout target %0d", target);
    end
  endtask

  initial begin
    bit ok;
    reset = 1'b1; bcd = '0; bcd_valid = 1'b0;
    blank_lz = 1'b0;
    step(3);
    check("reset_off", {an, seg}, {4'hF, 7'h7F});
    reset = 1'b0;
    step(1);
    check("first_digit", {an, seg}, {4'b1110, 7'b1000000});
    step(3);
    check("first_gap", {an, seg}, {4'hF, 7'h7F});
    step(1);
    check("tens_zero", {an, seg}, {4'b1101, 7'b1000000});
    step(2 * PER);

    blank_lz = 1'b1;
    capture(12'h255);
    step(2 * PER);
    capture(12'h007);
    step(2 * PER);
    blank_lz = 1'b0;
    step(2 * PER);
    capture(12'h0A3);
    step(2 * PER);

    // Capture on the same edge the scan returns to ones.
    wait_p(PER - 1, ok);
    if (ok) begin
      capture(12'h128);
      check("swap_old", {an, seg}, {4'b1110, 7'b0110000});
      step(1);
      check("swap_new", {an, seg}, {4'b1110, 7'b0000000});
    end

    wait_p(RD, ok);
    if (ok) begin
      reset = 1'b1;
      step(1);
      check("mid_reset", {an, seg}, {4'hF, 7'h7F});
      reset = 1'b0;
      step(1);
      check("post_reset", {an, seg}, {4'b1110, 7'b1000000});
    end

    for (int i = 0; i < 600; i++) begin
      bcd = {($urandom_range(0, 3) == 0) ? 4'd0
               : 4'($urandom_range(0, 15)),
             ($urandom_range(0, 2) == 0) ? 4'd0
               : 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15))};
      bcd_valid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 40) == 0) blank_lz = ~blank_lz;
      reset = ($urandom_range(0, 199) == 0);
      step(1);
    end
    reset = 1'b0; bcd_valid = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
